arq_seq_ctrl: RTL and testbench

ARQ_SEQ_CTRL -- requirements
Module: arq_seq_ctrl

---
 rtl/arq_seq_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_arq_seq_ctrl.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/arq_seq_ctrl.sv
// ARQ sequencing controller: tracks one outstanding frame, waits for the
// receiver verdict, and drives line-FIFO replays or a failure on NAK/timeout.
module arq_seq_ctrl #(
    parameter logic [7:0]  FRAME_LEN = 8'd68,
    parameter logic [23:0] TIMEOUT   = 24'd5000000,
    parameter logic [1:0]  MAX_RETRY = 2'd3
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_arq_en,
    input  logic       i_frame_valid,
    input  logic       i_frame_fas,
    input  logic       i_lf_byte,
    input  logic       i_ack_valid,
    input  logic       i_ack_good,
    input  logic       i_retrans_en,
    output logic       o_map_hold,
    output logic       o_read_line_fifo,
    output logic       o_flush,
    output logic       o_send_complete,
    output logic       o_fail,
    output logic       o_retrans_wait,
    output logic [2:0] o_state,
    output logic [1:0] o_retry_cnt
);

    typedef enum logic [2:0] {
        ST_IDLE         = 3'd0,
        ST_SEND         = 3'd1,
        ST_WAIT_ACK     = 3'd2,
        ST_RETRANS_WAIT = 3'd3,
        ST_REPLAY       = 3'd4,
        ST_FAIL         = 3'd5
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  byte_cnt_q, byte_cnt_d;
    logic [23:0] timer_q, timer_d;
    logic [1:0]  retry_q, retry_d;
    logic        flush_q, flush_d;
    logic        send_complete_q, send_complete_d;
    logic        fail_q, fail_d;
    logic        map_hold_q, map_hold_d;
    logic        read_lf_q, read_lf_d;
    logic        retrans_wait_q, retrans_wait_d;
    logic [7:0]  byte_cnt_inc_s;
    logic [23:0] timer_inc_s;

    assign byte_cnt_inc_s = byte_cnt_q + 8'd1;
    assign timer_inc_s    = (timer_q == 24'hFF_FFFF) ? timer_q : (timer_q + 24'd1);

    // Next-state, counter and pulse computation.
    always_comb begin
        state_d         = state_q;
        byte_cnt_d      = byte_cnt_q;
        timer_d         = timer_q;
        retry_d         = retry_q;
        flush_d         = 1'b0;
        send_complete_d = 1'b0;
        fail_d          = 1'b0;
        if (!i_arq_en) begin
            state_d    = ST_IDLE;
            byte_cnt_d = 8'd0;
            timer_d    = 24'd0;
            retry_d    = 2'd0;
            if (state_q != ST_IDLE) begin
                flush_d = 1'b1;
            end else begin
                flush_d = 1'b0;
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (i_frame_valid && i_frame_fas) begin
                        state_d    = ST_SEND;
                        byte_cnt_d = 8'd1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_SEND: begin
                    if (i_frame_valid) begin
                        byte_cnt_d = byte_cnt_inc_s;
                        if (byte_cnt_inc_s == FRAME_LEN) begin
                            state_d = ST_WAIT_ACK;
                            timer_d = 24'd0;
                        end else begin
                            state_d = ST_SEND;
                        end
                    end else begin
                        state_d = ST_SEND;
                    end
                end
                ST_WAIT_ACK: begin
                    // A good ACK outranks a timeout landing on the same cycle.
                    if (i_ack_valid && i_ack_good) begin
                        state_d         = ST_IDLE;
                        send_complete_d = 1'b1;
                        flush_d         = 1'b1;
                        retry_d         = 2'd0;
                        byte_cnt_d      = 8'd0;
                        timer_d         = 24'd0;
                    end else if (i_ack_valid || (timer_q == (TIMEOUT - 24'd1))) begin
                        if (retry_q < MAX_RETRY) begin
                            state_d = ST_RETRANS_WAIT;
                            retry_d = retry_q + 2'd1;
                        end else begin
                            state_d = ST_FAIL;
                            fail_d  = 1'b1;
                            flush_d = 1'b1;
                        end
                    end else begin
                        timer_d = timer_inc_s;
                    end
                end
                ST_RETRANS_WAIT: begin
                    if (i_retrans_en) begin
                        state_d    = ST_REPLAY;
                        byte_cnt_d = 8'd0;
                    end else begin
                        state_d = ST_RETRANS_WAIT;
                    end
                end
                ST_REPLAY: begin
                    if (i_lf_byte) begin
                        byte_cnt_d = byte_cnt_inc_s;
                        if (byte_cnt_inc_s == FRAME_LEN) begin
                            state_d = ST_WAIT_ACK;
                            timer_d = 24'd0;
                        end else begin
                            state_d = ST_REPLAY;
                        end
                    end else begin
                        state_d = ST_REPLAY;
                    end
                end
                ST_FAIL: begin
                    state_d    = ST_IDLE;
                    retry_d    = 2'd0;
                    byte_cnt_d = 8'd0;
                    timer_d    = 24'd0;
                end
                default: begin
                    state_d    = ST_IDLE;
                    retry_d    = 2'd0;
                    byte_cnt_d = 8'd0;
                    timer_d    = 24'd0;
                end
            endcase
        end
    end

    // Level outputs are decoded from the next state so they register alongside it.
    always_comb begin
        map_hold_d     = (state_d == ST_WAIT_ACK) || (state_d == ST_RETRANS_WAIT) ||
                         (state_d == ST_REPLAY)   || (state_d == ST_FAIL);
        read_lf_d      = (state_d == ST_REPLAY);
        retrans_wait_d = (state_d == ST_RETRANS_WAIT);
    end

    // State, counters and all outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q         <= ST_IDLE;
            byte_cnt_q      <= 8'd0;
            timer_q         <= 24'd0;
            retry_q         <= 2'd0;
            flush_q         <= 1'b0;
            send_complete_q <= 1'b0;
            fail_q          <= 1'b0;
            map_hold_q      <= 1'b0;
            read_lf_q       <= 1'b0;
            retrans_wait_q  <= 1'b0;
        end else begin
            state_q         <= state_d;
            byte_cnt_q      <= byte_cnt_d;
            timer_q         <= timer_d;
            retry_q         <= retry_d;
            flush_q         <= flush_d;
            send_complete_q <= send_complete_d;
            fail_q          <= fail_d;
            map_hold_q      <= map_hold_d;
            read_lf_q       <= read_lf_d;
            retrans_wait_q  <= retrans_wait_d;
        end
    end

    assign o_state          = state_q;
    assign o_retry_cnt      = retry_q;
    assign o_flush          = flush_q;
    assign o_send_complete  = send_complete_q;
    assign o_fail           = fail_q;
    assign o_map_hold       = map_hold_q;
    assign o_read_line_fifo = read_lf_q;
    assign o_retrans_wait   = retrans_wait_q;

endmodule

// File: tb/tb_arq_seq_ctrl.sv
// Bench for arq_seq_ctrl: directed scenarios plus random traffic, every cycle
// compared against a frame-level reference model.
module tb_arq_seq_ctrl;

    localparam logic [7:0]  FL  = 8'd4;
    localparam logic [23:0] TO  = 24'd8;
    localparam logic [1:0]  MR  = 2'd2;

    logic       clk = 1'b0;
    logic       rst, en, fv, fas, lf, av, ag, re;
    logic       o_map_hold, o_read_line_fifo, o_flush, o_send_complete;
    logic       o_fail, o_retrans_wait;
    logic [2:0] o_state;
    logic [1:0] o_retry_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: mode number, bytes still owed, cycles waited, retries used.
    int m_mode, m_left, m_waited, m_retries;
    logic m_done, m_flush, m_fail;

    always #5 clk = ~clk;

    arq_seq_ctrl #(.FRAME_LEN(FL), .TIMEOUT(TO), .MAX_RETRY(MR)) dut (
        .i_clk(clk), .i_rst(rst), .i_arq_en(en), .i_frame_valid(fv),
        .i_frame_fas(fas), .i_lf_byte(lf), .i_ack_valid(av), .i_ack_good(ag),
        .i_retrans_en(re), .o_map_hold(o_map_hold), .o_read_line_fifo(o_read_line_fifo),
        .o_flush(o_flush), .o_send_complete(o_send_complete), .o_fail(o_fail),
        .o_retrans_wait(o_retrans_wait), .o_state(o_state), .o_retry_cnt(o_retry_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic m_step();
        m_done  = 1'b0;
        m_flush = 1'b0;
        m_fail  = 1'b0;
        if (rst) begin
            m_mode = 0; m_left = 0; m_waited = 0; m_retries = 0;
        end else if (!en) begin
            m_flush = (m_mode != 0);
            m_mode = 0; m_left = 0; m_waited = 0; m_retries = 0;
        end else begin
            case (m_mode)
                0: if (fv && fas) begin m_mode = 1; m_left = int'(FL) - 1; end
                1: if (fv) begin
                       m_left--;
                       if (m_left == 0) begin m_mode = 2; m_waited = 0; end
                   end
                2: if (av && ag) begin
                       m_done = 1'b1; m_flush = 1'b1; m_mode = 0; m_retries = 0;
                   end else if (av || m_waited == int'(TO) - 1) begin
                       if (m_retries < int'(MR)) begin m_mode = 3; m_retries++; end
                       else begin m_mode = 5; m_fail = 1'b1; m_flush = 1'b1; end
                   end else m_waited++;
                3: if (re) begin m_mode = 4; m_left = int'(FL); end
                4: if (lf) begin
                       m_left--;
                       if (m_left == 0) begin m_mode = 2; m_waited = 0; end
                   end
                default: begin m_mode = 0; m_retries = 0; end
            endcase
        end
    endtask

    task automatic tick();
        m_step();
        @(posedge clk);
        #1;
        chk("state", o_state, m_mode);
        chk("retry_cnt", o_retry_cnt, m_retries);
        chk("map_hold", o_map_hold, (m_mode >= 2 && m_mode <= 5));
        chk("read_line_fifo", o_read_line_fifo, (m_mode == 4));
        chk("retrans_wait", o_retrans_wait, (m_mode == 3));
        chk("flush", o_flush, m_flush);
        chk("send_complete", o_send_complete, m_done);
        chk("fail", o_fail, m_fail);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic send_frame();
        fv = 1'b1; fas = 1'b1; tick();
        fas = 1'b0; ticks(int'(FL) - 1);
        fv = 1'b0;
    endtask

    task automatic replay();
        re = 1'b1; tick(); re = 1'b0;
        lf = 1'b1; ticks(int'(FL)); lf = 1'b0;
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; fv = 1'b0; fas = 1'b0; lf = 1'b0;
        av = 1'b0; ag = 1'b0; re = 1'b0;
        ticks(2);
        chk("reset_state", o_state, 3'd0);
        chk("reset_hold", o_map_hold, 1'b0);
        rst = 1'b0;

        // Bytes without FAS in IDLE are ignored.
        fv = 1'b1; ticks(3); fv = 1'b0;
        chk("no_fas_idle", o_state, 3'd0);

        // Clean frame acknowledged two cycles after completion.
        send_frame();
        chk("frame_to_wait", o_state, 3'd2);
        ticks(2);
        av = 1'b1; ag = 1'b1; tick(); av = 1'b0; ag = 1'b0;
        chk("ack_idle", o_state, 3'd0);
        chk("ack_complete", o_send_complete, 1'b1);
        chk("ack_flush", o_flush, 1'b1);
        tick();
        chk("complete_one_cycle", o_send_complete, 1'b0);

        // NAK, replay, then ACK.
        send_frame();
        av = 1'b1; ag = 1'b0; tick(); av = 1'b0;
        chk("nak_rtw", o_state, 3'd3);
        chk("nak_retry", o_retry_cnt, 2'd1);
        re = 1'b1; tick(); re = 1'b0;
        chk("replay_state", o_state, 3'd4);
        chk("replay_read", o_read_line_fifo, 1'b1);
        lf = 1'b1; ticks(int'(FL)); lf = 1'b0;
        chk("replay_done", o_state, 3'd2);
        chk("replay_read_off", o_read_line_fifo, 1'b0);
        av = 1'b1; ag = 1'b1; tick(); av = 1'b0; ag = 1'b0;
        chk("replay_ack", o_state, 3'd0);

        // Timeout after exactly TIMEOUT cycles; then ACK coinciding with timeout.
        send_frame();
        ticks(int'(TO) - 1);
        chk("timeout_not_yet", o_state, 3'd2);
        tick();
        chk("timeout_rtw", o_state, 3'd3);
        replay();
        ticks(int'(TO) - 1);
        av = 1'b1; ag = 1'b1; tick(); av = 1'b0; ag = 1'b0;
        chk("ack_beats_timeout", o_state, 3'd0);
        chk("ack_beats_timeout_retry", o_retry_cnt, 2'd0);

        // Three NAKs exhaust the retries.
        send_frame();
        av = 1'b1; ag = 1'b0; tick(); av = 1'b0;
        replay();
        av = 1'b1; tick(); av = 1'b0;
        chk("second_nak_retry", o_retry_cnt, 2'd2);
        replay();
        av = 1'b1; tick(); av = 1'b0;
        chk("fail_state", o_state, 3'd5);
        chk("fail_pulse", o_fail, 1'b1);
        tick();
        chk("fail_to_idle", o_state, 3'd0);
        chk("fail_retry_clr", o_retry_cnt, 2'd0);
        chk("fail_one_cycle", o_fail, 1'b0);

        // Disable in REPLAY, then reset in WAIT_ACK.
        send_frame();
        av = 1'b1; tick(); av = 1'b0;
        re = 1'b1; tick(); re = 1'b0;
        lf = 1'b1; ticks(2); lf = 1'b0;
        en = 1'b0; tick();
        chk("disable_idle", o_state, 3'd0);
        chk("disable_flush", o_flush, 1'b1);
        fv = 1'b1; fas = 1'b1; tick(); fv = 1'b0; fas = 1'b0;
        chk("disable_flush_once", o_flush, 1'b0);
        chk("disable_untracked", o_state, 3'd0);
        en = 1'b1;
        send_frame();
        tick();
        rst = 1'b1; tick(); rst = 1'b0;
        chk("rst_state", o_state, 3'd0);
        chk("rst_no_flush", o_flush, 1'b0);

        // Random traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            rst = ($urandom_range(0, 299) == 0);
            en  = ($urandom_range(0, 79) != 0);
            fv  = $urandom_range(0, 1);
            fas = ($urandom_range(0, 5) == 0);
            lf  = $urandom_range(0, 1);
            av  = ($urandom_range(0, 7) == 0);
            ag  = $urandom_range(0, 1);
            re  = ($urandom_range(0, 2) == 0);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
